rcp_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the single shared combinational reciprocal unit.

---
 rtl/rcp_arbiter.sv | 106 ++++++++++
 tb/tb_rcp_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcp_arbiter.sv
// Round-robin arbiter and sequencer for the shared combinational reciprocal unit.
// One operand is latched per transaction, held SETTLE cycles, then the result is registered and acked.
module rcp_arbiter #(
  parameter int NREQ   = 3,
  parameter int WIDTH  = 24,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*WIDTH-1:0]   i_op,
  output logic [NREQ-1:0]         o_ack,
  output logic [WIDTH-1:0]        o_result,
  output logic                    o_sat,
  output logic                    o_busy,
  output logic [WIDTH-1:0]        o_rcp_in,
  input  logic [WIDTH-1:0]        i_rcp_out,
  input  logic                    i_rcp_sat
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LOAD} state_t;

  state_t            stateReg, stateNext;
  logic [PW-1:0]     grantReg, ptrReg, pick;
  logic              found;
  logic [3:0]        cntReg;
  logic [NREQ-1:0]   elig;
  logic [WIDTH-1:0]  opArr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_op
      assign opArr[gi] = i_op[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A client whose ack is visible this cycle is held off so it cannot be served twice.
  assign elig   = i_req & ~o_ack;
  assign o_busy = (stateReg != S_IDLE);

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptrReg) + k) % NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_IDLE:   if (found) stateNext = (SETTLE > 0) ? S_SETTLE : S_LOAD;
      S_SETTLE: if (cntReg == 4'd1) stateNext = S_LOAD;
      S_LOAD:   stateNext = S_IDLE;
      default:  stateNext = S_IDLE;
    endcase
    if (i_clear) stateNext = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stateReg <= S_IDLE;
    else          stateReg <= stateNext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_ack    <= '0;
      o_result <= '0;
      o_sat    <= 1'b0;
      o_rcp_in <= '0;
      grantReg <= '0;
      cntReg   <= '0;
      ptrReg   <= PW'(NREQ-1);
    end else begin
      o_ack <= '0;
      if (i_clear) begin
        // Abort drops the op but leaves the last result and operand visible.
        ptrReg <= PW'(NREQ-1);
      end else begin
        case (stateReg)
          S_IDLE: if (found) begin
            grantReg <= pick;
            o_rcp_in <= opArr[pick];
            cntReg   <= 4'(SETTLE);
          end
          S_SETTLE: cntReg <= cntReg - 4'd1;
          S_LOAD: begin
            o_result <= i_rcp_out;
            o_sat    <= i_rcp_sat;
            o_ack    <= NREQ'(1) << grantReg;
            ptrReg   <= grantReg;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rcp_arbiter.sv
// Self-checking bench for rcp_arbiter: reciprocal model, scoreboard of expected acks,
// rotation, clear, async reset and a SETTLE=0 instance.
module tb_rcp_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, clear;
  logic [NREQ-1:0]   req, ack;
  logic [NREQ*W-1:0] op;
  logic [W-1:0]      result, rcpIn, rcpOut;
  logic              sat, busy, rcpSat;

  logic              clear0;
  logic [NREQ-1:0]   req0, ack0;
  logic [NREQ*W-1:0] op0;
  logic [W-1:0]      result0, rcpIn0, rcpOut0;
  logic              sat0, busy0, rcpSat0;

  rcp_arbiter #(.NREQ(NREQ), .WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .i_clear(clear), .i_req(req), .i_op(op),
    .o_ack(ack), .o_result(result), .o_sat(sat), .o_busy(busy),
    .o_rcp_in(rcpIn), .i_rcp_out(rcpOut), .i_rcp_sat(rcpSat));

  rcp_arbiter #(.NREQ(NREQ), .WIDTH(W), .SETTLE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_clear(clear0), .i_req(req0), .i_op(op0),
    .o_ack(ack0), .o_result(result0), .o_sat(sat0), .o_busy(busy0),
    .o_rcp_in(rcpIn0), .i_rcp_out(rcpOut0), .i_rcp_sat(rcpSat0));

  // Q12.12 reciprocal: 2^24 / x, saturating to all-ones on zero or overflow.
  function automatic logic [W:0] rcpModel(input logic [W-1:0] x);
    longint q;
    if (x == '0) return {1'b1, {W{1'b1}}};
    q = 64'd16777216 / longint'(x);
    if (q > 64'hFFFFFF) return {1'b1, {W{1'b1}}};
    return {1'b0, q[W-1:0]};
  endfunction

  assign {rcpSat, rcpOut}   = rcpModel(rcpIn);
  assign {rcpSat0, rcpOut0} = rcpModel(rcpIn0);

  typedef struct {
    int         client;
    logic [W-1:0] res;
    logic       s;
  } exp_t;

  exp_t expQ[$];
  int   ackCyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   reqLeft[NREQ];

  task automatic setOp(input int k, input logic [W-1:0] v);
    op[k*W +: W] = v;
  endtask

  task automatic raise(input int k, input int n, input logic [W-1:0] v);
    setOp(k, v);
    reqLeft[k] = n;
    req[k] = 1'b1;
  endtask

  task automatic pushExp(input int k, input logic [W-1:0] v);
    exp_t e;
    e.client = k;
    {e.s, e.res} = rcpModel(v);
    expQ.push_back(e);
  endtask

  // Advance one cycle, sample at the falling edge, score any ack and retire the requester.
  task automatic step();
    exp_t e;
    int who;
    @(negedge clk);
    cyc++;
    if (ack !== '0) begin
      who = -1;
      for (int k = 0; k < NREQ; k++) if (ack[k]) who = k;
      $display("ack client=%0d result=%h sat=%b cycle=%0d", who, result, sat, cyc);
      ackCyc.push_back(cyc);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack ack=%b required none", ack);
      end else begin
        e = expQ.pop_front();
        if (ack !== (NREQ'(1) << e.client) || result !== e.res || sat !== e.s) begin
          errors++;
          $display("FAIL ack_data ack=%b result=%h sat=%b required ack=%b result=%h sat=%b",
                   ack, result, sat, NREQ'(1) << e.client, e.res, e.s);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (ack[k]) begin
          if (reqLeft[k] > 0) reqLeft[k]--;
          req[k] = (reqLeft[k] > 0);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkSpacing(input string name, input int nAcks, input int gap);
    checks++;
    if (ackCyc.size() != nAcks) begin
      errors++;
      $display("FAIL %s_count acks=%0d required %0d", name, ackCyc.size(), nAcks);
    end else begin
      for (int i = 1; i < nAcks; i++) begin
        checks++;
        if (ackCyc[i] - ackCyc[i-1] !== gap) begin
          errors++;
          $display("FAIL %s_gap%0d gap=%0d required %0d", name, i, ackCyc[i] - ackCyc[i-1], gap);
        end
      end
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    clear = 1'b0; clear0 = 1'b0;
    req = '0; req0 = '0; op = '0; op0 = '0;
    for (int k = 0; k < NREQ; k++) reqLeft[k] = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear = 1'b0; clear0 = 1'b0;
    req = '0; req0 = '0; op = '0; op0 = '0;
    for (int k = 0; k < NREQ; k++) reqLeft[k] = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== '0 || result !== '0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_out ack=%b result=%h sat=%b required 0 0 0", ack, result, sat);
    end
    checks++;
    if (busy !== 1'b0 || rcpIn !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b rcp_in=%h required 0 0", busy, rcpIn);
    end
    checks++;
    if (ack0 !== '0 || result0 !== '0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_s0 ack=%b result=%h busy=%b required 0", ack0, result0, busy0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int start;
    ackCyc.delete();
    raise(0, 1, 24'h002000);
    pushExp(0, 24'h002000);
    start = cyc;
    drain(20);
    checks++;
    if (ackCyc.size() != 1 || ackCyc[0] - start != 3) begin
      errors++;
      $display("FAIL single_latency acks=%0d cycles=%0d required 1 3", ackCyc.size(),
               (ackCyc.size() > 0) ? ackCyc[0] - start : -1);
    end
    checks++;
    if (result !== 24'h000800 || sat !== 1'b0) begin
      errors++;
      $display("FAIL single_result result=%h sat=%b required 000800 0", result, sat);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] v [NREQ];
    v[0] = 24'h001000; v[1] = 24'h000800; v[2] = 24'h003000;
    doReset();
    ackCyc.delete();
    for (int k = 0; k < NREQ; k++) raise(k, 2, v[k]);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NREQ; k++) pushExp(k, v[k]);
    drain(60);
    checkSpacing("rr", 6, 3);
  endtask

  task automatic test_subset();
    ackCyc.delete();
    idle(1);
    raise(0, 1, 24'h000400);
    raise(2, 1, 24'h006000);
    pushExp(0, 24'h000400);
    pushExp(2, 24'h006000);
    drain(30);
    idle(4);
    checks++;
    if (ackCyc.size() != 2) begin
      errors++;
      $display("FAIL subset_count acks=%0d required 2", ackCyc.size());
    end
  endtask

  task automatic test_back_to_back();
    ackCyc.delete();
    raise(1, 3, 24'h001000);
    for (int r = 0; r < 3; r++) pushExp(1, 24'h001000);
    drain(40);
    checkSpacing("b2b", 3, 4);
  endtask

  task automatic test_sat_latch();
    idle(1);
    raise(1, 1, 24'h000000);
    pushExp(1, 24'h000000);
    drain(20);
    checks++;
    if (sat !== 1'b1 || result !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL sat_zero result=%h sat=%b required ffffff 1", result, sat);
    end
    idle(1);
    raise(1, 1, 24'h004000);
    pushExp(1, 24'h004000);
    step();
    checks++;
    if (busy !== 1'b1 || rcpIn !== 24'h004000) begin
      errors++;
      $display("FAIL latch_op busy=%b rcp_in=%h required 1 004000", busy, rcpIn);
    end
    setOp(1, 24'h001000);
    drain(20);
    checks++;
    if (result !== 24'h000400 || sat !== 1'b0) begin
      errors++;
      $display("FAIL latch_result result=%h sat=%b required 000400 0", result, sat);
    end
  endtask

  task automatic test_clear();
    idle(1);
    raise(2, 1, 24'h002000);
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre busy=%b required 1", busy);
    end
    clear = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || ack !== '0 || result !== 24'h000400) begin
      errors++;
      $display("FAIL clear_abort busy=%b ack=%b result=%h required 0 000 000400", busy, ack, result);
    end
    raise(0, 1, 24'h001000);
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold busy=%b required 0", busy);
    end
    clear = 1'b0;
    pushExp(0, 24'h001000);
    pushExp(2, 24'h002000);
    drain(30);
  endtask

  task automatic test_async_reset();
    idle(1);
    raise(0, 1, 24'h002000);
    step();
    step();
    checks++;
    if (busy !== 1'b1 || result === '0) begin
      errors++;
      $display("FAIL areset_pre busy=%b result=%h required 1 nonzero", busy, result);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (ack !== '0 || result !== '0 || busy !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL areset_now ack=%b result=%h busy=%b sat=%b required 0", ack, result, busy, sat);
    end
    reqLeft[0] = 0;
    req = '0;
    idle(2);
    reset_n = 1'b1;
    idle(4);
  endtask

  task automatic test_settle0();
    int n = 0;
    op0[1*W +: W] = 24'h002000;
    req0[1] = 1'b1;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (ack0 !== '0) break;
    end
    $display("ack0 client_mask=%b result=%h sat=%b after=%0d", ack0, result0, sat0, n);
    req0 = '0;
    checks++;
    if (n != 2 || ack0 !== 3'b010) begin
      errors++;
      $display("FAIL s0_latency cycles=%0d ack=%b required 2 010", n, ack0);
    end
    checks++;
    if (result0 !== 24'h000800 || sat0 !== 1'b0) begin
      errors++;
      $display("FAIL s0_result result=%h sat=%b required 000800 0", result0, sat0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_subset();
    test_back_to_back();
    test_sat_latch();
    test_clear();
    test_async_reset();
    test_settle0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
